// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared definitions for the chunked, pipelined adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_DATA_WIDTH / DEF_CHUNK_WIDTH : default operand and slice widths
//   num_stages()                     : pipeline depth for a given width pair
//   pca_stage_t                      : per-stage pipeline record at the default widths
package pipelined_chunk_adder_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_CHUNK_WIDTH = 8;

    // One pipeline stage per chunk.
    function automatic int num_stages(input int data_width, input int chunk_width);
        return data_width / chunk_width;
    endfunction

    localparam int DEF_NUM_STAGES = num_stages(DEF_DATA_WIDTH, DEF_CHUNK_WIDTH);

    // Per-stage record. sum holds the chunks already resolved (low chunks),
    // a/b carry the operands forward so later stages can pick their chunk.
    // The top module declares the same layout at its own parameter widths.
    typedef struct packed {
        logic                      valid;
        logic                      carry;
        logic [DEF_DATA_WIDTH-1:0] sum;
        logic [DEF_DATA_WIDTH-1:0] a;
        logic [DEF_DATA_WIDTH-1:0] b;
    } pca_stage_t;

endpackage

// File: rtl/pipelined_chunk_adder_chunk.sv
// Combinational CHUNK_WIDTH-bit ripple slice: sum, carry-out and carry into the MSB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage holds its inputs.
//
// Ports:
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   sum   : chunk sum
//   cout  : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (feeds signed-overflow detection)
module chunk_adder #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   cmsb
);

    localparam int MSB = CHUNK_WIDTH - 1;

    // Add everything below the MSB first so the carry into the MSB is
    // available as its own signal; the MSB is then a single full adder.
    logic [CHUNK_WIDTH-1:0] low;

    assign low  = {1'b0, a[MSB-1:0]} + {1'b0, b[MSB-1:0]} + {{(CHUNK_WIDTH-1){1'b0}}, cin};
    assign cmsb = low[MSB];
    assign sum  = {a[MSB] ^ b[MSB] ^ cmsb, low[MSB-1:0]};
    assign cout = (a[MSB] & b[MSB]) | (cmsb & (a[MSB] ^ b[MSB]));

endmodule

// File: rtl/pipelined_chunk_adder.sv
// DATA_WIDTH add/subtract, one CHUNK_WIDTH slice per stage, carry registered between stages.
// Latency: NUM_STAGES-1 cycles from accept edge to out_valid; one beat per cycle throughput.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   sub                  : 1 = a - b (cin ignored), 0 = a + b + cin
//   out_valid / out_ready: result handshake (sum, cout[, ovf])
//   cout                 : carry out of the MSB; in subtract mode 1 = no borrow
//   ovf                  : signed overflow, present only with PIPELINED_CHUNK_ADDER_OVF_EN
//
// Optional feature macro: PIPELINED_CHUNK_ADDER_OVF_EN (adds the ovf port and its register).
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int NUM_STAGES = num_stages(DATA_WIDTH, CHUNK_WIDTH);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_data_width
        $error("pipelined_chunk_adder: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if (CHUNK_WIDTH < 2) begin : g_bad_chunk_width
        $error("pipelined_chunk_adder: CHUNK_WIDTH must be at least 2");
    end

    typedef struct packed {
        logic                  valid;
        logic                  carry;
        logic [DATA_WIDTH-1:0] sum;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } stage_t;

    logic                  advance;
    logic [DATA_WIDTH-1:0] b_eff;
    logic                  c0;

    stage_t stage_d [NUM_STAGES];
    stage_t stage_q [NUM_STAGES];

    // Carry into each chunk MSB. Only the final stage's bit is ever consumed,
    // and only when overflow detection is built in.
    logic [NUM_STAGES-1:0] msb_carry_unused;

    // Single global enable: every stage moves together, bubbles included.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction as a + ~b + 1.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        stage_t                  src;
        logic [CHUNK_WIDTH-1:0]  chunk_sum;
        logic                    chunk_cout;
        logic [DATA_WIDTH-1:0]   merged;

        if (k == 0) begin : g_first
            assign src = '{valid: in_valid, carry: c0, sum: '0, a: a, b: b_eff};
        end else begin : g_next
            assign src = stage_q[k-1];
        end

        chunk_adder #(
            .CHUNK_WIDTH (CHUNK_WIDTH)
        ) u_chunk (
            .a    (src.a[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
            .b    (src.b[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
            .cin  (src.carry),
            .sum  (chunk_sum),
            .cout (chunk_cout),
            .cmsb (msb_carry_unused[k])
        );

        // Resolved low chunks pass through; this stage fills in chunk k.
        always_comb begin
            merged = src.sum;
            merged[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum;
        end

        assign stage_d[k] = '{valid: src.valid, carry: chunk_cout, sum: merged,
                              a: src.a, b: src.b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid = stage_q[NUM_STAGES-1].valid;
    assign sum       = stage_q[NUM_STAGES-1].sum;
    assign cout      = stage_q[NUM_STAGES-1].carry;

`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    // Registered alongside the last stage so it shares its valid and stall.
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= msb_carry_unused[NUM_STAGES-1] ^ stage_d[NUM_STAGES-1].carry;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed self-checking bench for pipelined_chunk_adder at DATA_WIDTH=16, CHUNK_WIDTH=4.
// Latency: expects results NUM_STAGES-1 = 3 edges after the accept edge.
// Backpressure: exercises stalls via out_ready and checks hold/ordering.
module tb_pipelined_chunk_adder;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum;
    logic          cout;
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_chunk_adder #(
        .DATA_WIDTH  (DW),
        .CHUNK_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Drive one beat into an otherwise idle pipe and wait (bounded) for it.
    // lat counts edges after the accept edge until out_valid is seen.
    task automatic run_one(input logic [DW-1:0] ta, input logic [DW-1:0] tb_in,
                           input logic tcin, input logic tsub,
                           output logic [DW-1:0] rsum, output logic rcout,
                           output logic rovf, output int lat);
        a        = ta;
        b        = tb_in;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rsum  = sum;
        rcout = cout;
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
        rovf  = ovf;
`else
        rovf  = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] rs;
        logic          rc;
        logic          ro;
        int            lat;
        idle(4);
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wrap_latency: got %0d expected 3", lat); end
        checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL wrap_sum: got %h expected 0000", rs); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b expected 1", rc); end
        run_one(16'h1234, 16'h4321, 1'b1, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 16'h5556) begin errors++; $display("FAIL add_cin_sum: got %h expected 5556", rs); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL add_cin_cout: got %b expected 0", rc); end
    endtask

    task automatic test_subtract;
        logic [DW-1:0] rs;
        logic          rc;
        logic          ro;
        int            lat;
        idle(4);
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum: got %h expected fffe", rs); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout: got %b expected 0", rc); end
        run_one(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h0002) begin errors++; $display("FAIL sub_sum: got %h expected 0002", rs); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_cout: got %b expected 1", rc); end
        // cin must be ignored while subtracting
        run_one(16'h0007, 16'h0005, 1'b1, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h0002) begin errors++; $display("FAIL sub_cin_ignored_sum: got %h expected 0002", rs); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_cin_ignored_cout: got %b expected 1", rc); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] va   [8] = '{16'h0001, 16'h00FF, 16'h8000, 16'h1000,
                                    16'hABCD, 16'h0000, 16'hFFFF, 16'h0F0F};
        logic [DW-1:0] vb   [8] = '{16'h0002, 16'h0001, 16'h8000, 16'h0001,
                                    16'h1111, 16'h0001, 16'h0000, 16'hF0F0};
        logic          vcin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic          vsub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] es   [8] = '{16'h0003, 16'h0101, 16'h0000, 16'h0FFF,
                                    16'hBCDE, 16'hFFFF, 16'h0000, 16'hFFFF};
        logic          ec   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic          exp_v;
        idle(4);
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin
                a   = va[c];
                b   = vb[c];
                cin = vcin[c];
                sub = vsub[c];
            end
            #1;
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready); end
            end
            exp_v = (c >= 4 && c <= 11);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b expected %b", c, out_valid, exp_v); end
            if (c >= 4 && c <= 11) begin
                checks++; if (sum !== es[c-4]) begin errors++; $display("FAIL b2b_sum[%0d]: got %h expected %h", c-4, sum, es[c-4]); end
                checks++; if (cout !== ec[c-4]) begin errors++; $display("FAIL b2b_cout[%0d]: got %b expected %b", c-4, cout, ec[c-4]); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] va  [6] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        logic [DW-1:0] es  [6] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656};
        int            sent = 0;
        int            recv = 0;
        logic          acc;
        logic          cons;
        idle(4);
        b   = 16'h0101;
        cin = 1'b0;
        sub = 1'b0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = (c >= 9);
            in_valid  = (sent < 6);
            a         = va[(sent < 6) ? sent : 5];
            #1;
            if (c >= 4 && c <= 8) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid); end
                checks++; if (sum !== es[0]) begin errors++; $display("FAIL bp_hold_sum[%0d]: got %h expected %h", c, sum, es[0]); end
                checks++; if (cout !== 1'b0) begin errors++; $display("FAIL bp_hold_cout[%0d]: got %b expected 0", c, cout); end
            end
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                checks++; if (sum !== es[recv]) begin errors++; $display("FAIL bp_drain_sum[%0d]: got %h expected %h", recv, sum, es[recv]); end
                recv++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 6) begin errors++; $display("FAIL bp_recv_count: got %0d expected 6", recv); end
        checks++; if (sent !== 6) begin errors++; $display("FAIL bp_sent_count: got %0d expected 6", sent); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup[%0d]: got %b expected 0", i, out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        idle(4);
        cin = 1'b0;
        sub = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a        = 16'h1111 * (c + 1);
            b        = 16'h2222;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b expected 0", cout); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
    task automatic test_ovf;
        logic [DW-1:0] rs;
        logic          rc;
        logic          ro;
        int            lat;
        idle(4);
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 16'h8000) begin errors++; $display("FAIL ovf_add_sum: got %h expected 8000", rs); end
        checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_add_ovf: got %b expected 1", ro); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL ovf_add_cout: got %b expected 0", rc); end
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++; if (rs !== 16'h7FFF) begin errors++; $display("FAIL ovf_sub_sum: got %h expected 7fff", rs); end
        checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_sub_ovf: got %b expected 1", ro); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout: got %b expected 1", rc); end
        run_one(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++; if (ro !== 1'b0) begin errors++; $display("FAIL ovf_none: got %b expected 0", ro); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        test_reset;
        test_wrap;
        test_subtract;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
        test_ovf;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
